bus_tenure_scheduler: RTL

BUS_TENURE_SCHEDULER -- requirements
Module: bus_tenure_scheduler

---
 rtl/bus_tenure_scheduler_if.sv | 24 ++
 rtl/bus_tenure_scheduler.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bus_tenure_scheduler_if.sv
// Handshake/bus bundle between the tenure scheduler and the Z3 slot masters.
// The scheduler connects through the slave modport. The master modport is the
// driving side and is used by whatever sources the requests.
interface bus_tenure_scheduler_if;
   logic       cpuclk_rising;
   logic [4:0] req;
   logic       sdmac_req;
   logic       release_done;
   logic [4:0] grant;
   logic       preempt;
   logic       timeout_err;
   logic [7:0] overrun_count;
   logic       busy;

   modport slave (
      input  cpuclk_rising, req, sdmac_req, release_done,
      output grant, preempt, timeout_err, overrun_count, busy
   );

   modport master (
      output cpuclk_rising, req, sdmac_req, release_done,
      input  grant, preempt, timeout_err, overrun_count, busy
   );
endinterface

// File: rtl/bus_tenure_scheduler.sv
// Round-robin bus tenure scheduler for five Z3 slots with tenure-based
// preemption and a hard timeout that forces release of a stuck holder.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | bus with CPU, waiting for a slot request while SDMAC is quiet
// GRANT   | one slot holds the bus, tenure counter running on cpuclk_rising
// PREEMPT | holder asked to finish, timeout counter running on cpuclk_rising
// RELEASE | grant removed, waiting for release_done before the next grant
module bus_tenure_scheduler #(
   parameter int unsigned TENURE_CYCLES = 64,
   parameter int unsigned HARD_TIMEOUT  = 32
) (
   input  logic                   clk100,
   input  logic                   reset,
   bus_tenure_scheduler_if.slave  bus
);

   localparam logic [7:0] TENURE_C = 8'(TENURE_CYCLES);
   localparam logic [7:0] HARD_C   = 8'(HARD_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      PREEMPT = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t     state_q;
   logic [4:0] grant_q;
   logic       preempt_q;
   logic       timeout_err_q;
   logic [7:0] overrun_q;
   logic       busy_q;
   logic [7:0] cnt_q;
   logic [2:0] last_holder_q;

   logic [2:0] winner_d;
   logic [2:0] idx;
   logic       found;
   logic       holder_req;
   logic       competing;

   // Round-robin pick: first requesting slot scanning upward from last_holder+1.
   always_comb begin
      winner_d = last_holder_q;
      found    = 1'b0;
      idx      = 3'd0;
      for (int i = 1; i <= 5; i++) begin
         idx = 3'((int'(last_holder_q) + i) % 5);
         if (!found && bus.req[idx]) begin
            winner_d = idx;
            found    = 1'b1;
         end
      end
   end

   // The holder is always last_holder, because it is updated on every grant.
   assign holder_req = bus.req[last_holder_q];
   assign competing  = (|(bus.req & ~grant_q)) | bus.sdmac_req;

   // Scheduler FSM. State and all outputs are registered here.
   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= 5'b00000;
         preempt_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_q     <= 8'd0;
         busy_q        <= 1'b0;
         cnt_q         <= 8'd0;
         last_holder_q <= 3'd4;
      end else begin
         timeout_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!bus.sdmac_req && (|bus.req)) begin
                  grant_q       <= 5'(5'b00001 << winner_d);
                  last_holder_q <= winner_d;
                  cnt_q         <= 8'd0;
                  busy_q        <= 1'b1;
                  state_q       <= GRANT;
               end
            end
            GRANT: begin
               if (!holder_req) begin
                  grant_q <= 5'b00000;
                  state_q <= RELEASE;
               end else if ((cnt_q >= TENURE_C) && competing) begin
                  preempt_q <= 1'b1;
                  cnt_q     <= 8'd0;
                  state_q   <= PREEMPT;
               end else if (bus.cpuclk_rising && (cnt_q != 8'hFF)) begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            PREEMPT: begin
               // A voluntary drop is tested first so that it wins a tie with the timeout.
               if (!holder_req) begin
                  grant_q   <= 5'b00000;
                  preempt_q <= 1'b0;
                  state_q   <= RELEASE;
               end else if (cnt_q >= HARD_C) begin
                  grant_q       <= 5'b00000;
                  preempt_q     <= 1'b0;
                  timeout_err_q <= 1'b1;
                  if (overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
                  state_q       <= RELEASE;
               end else if (bus.cpuclk_rising && (cnt_q != 8'hFF)) begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            RELEASE: begin
               grant_q <= 5'b00000;
               if (bus.release_done) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q   <= IDLE;
               grant_q   <= 5'b00000;
               preempt_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant         = grant_q;
   assign bus.preempt       = preempt_q;
   assign bus.timeout_err   = timeout_err_q;
   assign bus.overrun_count = overrun_q;
   assign bus.busy          = busy_q;

endmodule
